// File: rtl/mac_16_pkg.sv
// rtl/mac_16_pkg.sv - shared parameters and state encoding for the 16-tap MAC sequencer
package mac_16_pkg;

  localparam int DATA_W   = 32;
  localparam int N_TAPS   = 16;
  localparam int PIPE_LAT = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_16_sequencer_if.sv
// rtl/mac_16_sequencer_if.sv - sample stream in and result handshake out of the MAC sequencer
interface mac_16_sequencer_if #(
  parameter int DATA_W = mac_16_pkg::DATA_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_result;
  logic              m_valid;
  logic              m_ready;

  // Producer of samples and consumer of results
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_result, m_valid
  );

  // The sequencer itself
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_result, m_valid
  );

endinterface

// File: rtl/mac_16_sample_bank.sv
// rtl/mac_16_sample_bank.sv - 16-entry operand register bank written one sample at a time
module mac_16_sample_bank
  import mac_16_pkg::CNT_W;
#(
  parameter int DATA_W = mac_16_pkg::DATA_W,
  parameter int N_TAPS = mac_16_pkg::N_TAPS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [CNT_W-1:0]               widx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [N_TAPS-1:0][DATA_W-1:0]  taps
);

  // Write the indexed entry; reset wipes any partial frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps <= '0;
    end else if (we) begin
      taps[widx] <= wdata;
    end
  end

endmodule

// File: rtl/mac_16_sequencer.sv
// rtl/mac_16_sequencer.sv - serial-to-parallel loader that fires a 16-tap MAC and captures its sum
module mac_16_sequencer #(
  parameter int DATA_W   = mac_16_pkg::DATA_W,
  parameter int N_TAPS   = mac_16_pkg::N_TAPS,
  parameter int PIPE_LAT = mac_16_pkg::PIPE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  mac_16_sequencer_if.slave bus,
  output logic [DATA_W-1:0] a_0,
  output logic [DATA_W-1:0] a_1,
  output logic [DATA_W-1:0] a_2,
  output logic [DATA_W-1:0] a_3,
  output logic [DATA_W-1:0] a_4,
  output logic [DATA_W-1:0] a_5,
  output logic [DATA_W-1:0] a_6,
  output logic [DATA_W-1:0] a_7,
  output logic [DATA_W-1:0] a_8,
  output logic [DATA_W-1:0] a_9,
  output logic [DATA_W-1:0] a_10,
  output logic [DATA_W-1:0] a_11,
  output logic [DATA_W-1:0] a_12,
  output logic [DATA_W-1:0] a_13,
  output logic [DATA_W-1:0] a_14,
  output logic [DATA_W-1:0] a_15,
  output logic              mac_start,
  input  logic [DATA_W-1:0] mac_result,
  output logic              busy
);

  import mac_16_pkg::*;

  localparam int                LAT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_TAPS - 1);

  state_t                       state, state_d;
  logic [CNT_W-1:0]             cnt, cnt_d;
  logic [LAT_W-1:0]             lat, lat_d;
  logic                         load;
  logic                         capture;
  logic [DATA_W-1:0]            result_q;
  logic [N_TAPS-1:0][DATA_W-1:0] taps;

  mac_16_sample_bank #(
    .DATA_W (DATA_W),
    .N_TAPS (N_TAPS)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (load),
    .widx  (cnt),
    .wdata (bus.s_data),
    .taps  (taps)
  );

  // State, sample index and latency counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      lat   <= lat_d;
    end
  end

  // Next-state: load 16 samples, pulse the MAC, wait out its pipeline, hold the result
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lat_d   = lat;
    load    = 1'b0;
    capture = 1'b0;
    case (state)
      ST_LOAD: begin
        if (bus.s_valid) begin
          load  = 1'b1;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_d = ST_FIRE;
          end
        end
      end
      ST_FIRE: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat == LAT_LAST) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end else begin
          lat_d = lat + LAT_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Result register: sampled once when the MAC pipeline has drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= mac_result;
    end
  end

  assign bus.s_ready  = (state == ST_LOAD);
  assign bus.m_valid  = (state == ST_OUT);
  assign bus.m_result = result_q;
  assign mac_start    = (state == ST_FIRE);
  assign busy         = (state != ST_LOAD);

  assign a_0  = taps[0];
  assign a_1  = taps[1];
  assign a_2  = taps[2];
  assign a_3  = taps[3];
  assign a_4  = taps[4];
  assign a_5  = taps[5];
  assign a_6  = taps[6];
  assign a_7  = taps[7];
  assign a_8  = taps[8];
  assign a_9  = taps[9];
  assign a_10 = taps[10];
  assign a_11 = taps[11];
  assign a_12 = taps[12];
  assign a_13 = taps[13];
  assign a_14 = taps[14];
  assign a_15 = taps[15];

endmodule

// File: tb/tb_mac_16_sequencer.sv
// tb/tb_mac_16_sequencer.sv - self-checking bench for the 16-tap MAC sequencer
module tb_mac_16_sequencer;

  import mac_16_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_16_sequencer_if bus ();

  logic [N_TAPS-1:0][DATA_W-1:0] a_p;
  logic                          mac_start;
  logic                          busy;
  logic [DATA_W-1:0]             mac_result;

  mac_16_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .a_0        (a_p[0]),
    .a_1        (a_p[1]),
    .a_2        (a_p[2]),
    .a_3        (a_p[3]),
    .a_4        (a_p[4]),
    .a_5        (a_p[5]),
    .a_6        (a_p[6]),
    .a_7        (a_p[7]),
    .a_8        (a_p[8]),
    .a_9        (a_p[9]),
    .a_10       (a_p[10]),
    .a_11       (a_p[11]),
    .a_12       (a_p[12]),
    .a_13       (a_p[13]),
    .a_14       (a_p[14]),
    .a_15       (a_p[15]),
    .mac_start  (mac_start),
    .mac_result (mac_result),
    .busy       (busy)
  );

  // Pipelined MAC with every coefficient 65536: sum lands PIPE_LAT edges after the operands
  logic [DATA_W-1:0] mac_pipe [PIPE_LAT];

  function automatic logic [DATA_W-1:0] mac_sum(input logic [N_TAPS-1:0][DATA_W-1:0] ops);
    logic [DATA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) acc = acc + ops[i] * 32'd65536;
    return acc;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) mac_pipe[i] <= '0;
    end else begin
      mac_pipe[0] <= mac_sum(a_p);
      for (int i = 1; i < PIPE_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
  end
  assign mac_result = mac_pipe[PIPE_LAT-1];

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int start_cnt = 0;
  int rise_cnt = 0;
  bit mv_prev = 1'b0;

  // Expected result: sum of samples scaled by 2^16, wrapped to 32 bits
  function automatic logic [31:0] ref_result(input logic [31:0] s [16]);
    longint unsigned total;
    total = 0;
    foreach (s[i]) total += s[i];
    return 32'((total % 65536) * 65536);
  endfunction

  task automatic step();
    @(posedge clk);
    edges++;
    @(negedge clk);
    if (mac_start) start_cnt++;
    if (bus.m_valid && !mv_prev) rise_cnt++;
    mv_prev = bus.m_valid;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1/0, 2: random gaps
  task automatic send_frame(input logic [31:0] smp [16], input int mode,
                            output int last_edge, output bit ok);
    int i;
    int guard;
    bit ph;
    i = 0; guard = 0; ph = 1'b1; ok = 1'b1; last_edge = 0;
    while (i < 16) begin
      guard++;
      if (guard > 300) begin
        ok = 1'b0;
        break;
      end
      case (mode)
        0: bus.s_valid = 1'b1;
        1: begin bus.s_valid = ph; ph = ~ph; end
        default: bus.s_valid = ($urandom_range(0, 2) != 0);
      endcase
      bus.s_data = bus.s_valid ? smp[i] : $urandom;
      if (bus.s_valid && bus.s_ready) begin
        i++;
        if (i == 16) last_edge = edges + 1;
      end
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (bus.m_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (bus.m_valid) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0 || mac_start !== 1'b0 || bus.m_result !== '0 || a_p !== '0) begin
      errors++;
      $display("FAIL reset_state: m_valid=%b busy=%b mac_start=%b m_result=%h a_nonzero=%b, required all 0",
               bus.m_valid, busy, mac_start, bus.m_result, |a_p);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b required 1", bus.s_ready);
    end
  endtask

  task automatic test_back_to_back(input int mode, input string name);
    logic [31:0] smp [16];
    int last_edge, s0, r0;
    bit ok, vok;
    for (int i = 0; i < 16; i++) smp[i] = 32'(i + 1);
    bus.m_ready = 1'b1;
    s0 = start_cnt; r0 = rise_cnt;
    send_frame(smp, mode, last_edge, ok);
    wait_valid(40, vok);
    checks++;
    if (!ok || !vok) begin
      errors++;
      $display("FAIL %s_timeout: frame_ok=%b valid_ok=%b required 1/1", name, ok, vok);
    end
    checks++;
    if (edges - last_edge != PIPE_LAT + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, edges - last_edge, PIPE_LAT + 1);
    end
    checks++;
    if (bus.m_result !== 32'h0088_0000) begin
      errors++;
      $display("FAIL %s_result: got %h required 00880000", name, bus.m_result);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (a_p[i] !== smp[i]) begin
        errors++;
        $display("FAIL %s_a_%0d: got %h required %h", name, i, a_p[i], smp[i]);
      end
    end
    step();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: m_valid=%b s_ready=%b busy=%b required 0/1/0", name, bus.m_valid, bus.s_ready, busy);
    end
    checks++;
    if (start_cnt - s0 != 1 || rise_cnt - r0 != 1) begin
      errors++;
      $display("FAIL %s_pulses: mac_start=%0d m_valid_rises=%0d required 1/1", name, start_cnt - s0, rise_cnt - r0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] smp [16];
    int last_edge, s0, r0;
    bit ok, vok;
    for (int i = 0; i < 16; i++) smp[i] = 32'hFFFF_0000;
    bus.m_ready = 1'b1;
    s0 = start_cnt; r0 = rise_cnt;
    send_frame(smp, 0, last_edge, ok);
    wait_valid(40, vok);
    checks++;
    if (!ok || !vok || bus.m_result !== 32'h0) begin
      errors++;
      $display("FAIL wrap_result: got %h (ok=%b/%b) required 00000000", bus.m_result, ok, vok);
    end
    step();
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (rise_cnt - r0 != 1 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL wrap_once: m_valid_rises=%0d mac_start=%0d required 1/1", rise_cnt - r0, start_cnt - s0);
    end
  endtask

  task automatic test_hold();
    logic [31:0] smp [16];
    logic [31:0] held;
    int last_edge;
    bit ok, vok, bad;
    for (int i = 0; i < 16; i++) smp[i] = $urandom;
    bus.m_ready = 1'b0;
    send_frame(smp, 0, last_edge, ok);
    wait_valid(40, vok);
    checks++;
    if (!ok || !vok || bus.m_result !== ref_result(smp)) begin
      errors++;
      $display("FAIL hold_result: got %h required %h", bus.m_result, ref_result(smp));
    end
    held = bus.m_result;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = $urandom;
      step();
      if (bus.m_result !== held || bus.s_ready !== 1'b0 || busy !== 1'b1 || bus.m_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: m_result=%h s_ready=%b busy=%b m_valid=%b required %h/0/1/1",
               bus.m_result, bus.s_ready, busy, bus.m_valid, held);
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 32'hDEAD_BEEF;
    step();
    bus.s_valid = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || a_p[0] !== smp[0]) begin
      errors++;
      $display("FAIL hold_release: m_valid=%b s_ready=%b a_0=%h required 0/1/%h", bus.m_valid, bus.s_ready, a_p[0], smp[0]);
    end
  endtask

  task automatic test_abort_load();
    logic [31:0] smp [16];
    int last_edge, r0;
    bit ok, vok;
    r0 = rise_cnt;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = $urandom | 32'h1;
      step();
    end
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (a_p !== '0 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_clear: a_nonzero=%b busy=%b m_valid=%b required 0/0/0", |a_p, busy, bus.m_valid);
    end
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 16; i++) smp[i] = 32'd2;
    send_frame(smp, 0, last_edge, ok);
    wait_valid(40, vok);
    checks++;
    if (!ok || !vok || bus.m_result !== 32'h0020_0000) begin
      errors++;
      $display("FAIL abort_result: got %h required 00200000", bus.m_result);
    end
    step();
    checks++;
    if (rise_cnt - r0 != 1) begin
      errors++;
      $display("FAIL abort_results: m_valid_rises=%0d required 1", rise_cnt - r0);
    end
  endtask

  task automatic test_abort_wait();
    logic [31:0] smp [16];
    int last_edge, r0, s0;
    bit ok, vok;
    for (int i = 0; i < 16; i++) smp[i] = $urandom;
    bus.m_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(smp, 0, last_edge, ok);
    step();
    step();
    checks++;
    if (busy !== 1'b1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: busy=%b m_valid=%b s_ready=%b required 1/0/0", busy, bus.m_valid, bus.s_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_result !== '0) begin
      errors++;
      $display("FAIL wait_reset: busy=%b m_valid=%b m_result=%h required 0/0/0", busy, bus.m_valid, bus.m_result);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) step();
    checks++;
    if (rise_cnt != r0) begin
      errors++;
      $display("FAIL wait_no_result: m_valid_rises=%0d required 0", rise_cnt - r0);
    end
    for (int i = 0; i < 16; i++) smp[i] = $urandom;
    s0 = start_cnt;
    send_frame(smp, 2, last_edge, ok);
    wait_valid(40, vok);
    checks++;
    if (!ok || !vok || bus.m_result !== ref_result(smp)) begin
      errors++;
      $display("FAIL wait_next_frame: got %h required %h", bus.m_result, ref_result(smp));
    end
    step();
    checks++;
    if (rise_cnt - r0 != 1 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL wait_next_once: m_valid_rises=%0d mac_start=%0d required 1/1", rise_cnt - r0, start_cnt - s0);
    end
  endtask

  task automatic test_random();
    logic [31:0] smp [16];
    int last_edge, r0;
    bit ok, vok;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) smp[i] = $urandom;
      bus.m_ready = 1'b0;
      r0 = rise_cnt;
      send_frame(smp, 2, last_edge, ok);
      wait_valid(40, vok);
      checks++;
      if (!ok || !vok || bus.m_result !== ref_result(smp) || edges - last_edge != PIPE_LAT + 1) begin
        errors++;
        $display("FAIL random_%0d: got %h after %0d edges required %h after %0d", f,
                 bus.m_result, edges - last_edge, ref_result(smp), PIPE_LAT + 1);
      end
      repeat ($urandom_range(0, 3)) step();
      bus.m_ready = 1'b1;
      step();
      checks++;
      if (bus.m_valid !== 1'b0 || rise_cnt - r0 != 1) begin
        errors++;
        $display("FAIL random_%0d_release: m_valid=%b rises=%0d required 0/1", f, bus.m_valid, rise_cnt - r0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back(0, "back_to_back");
    test_wrap();
    test_back_to_back(1, "toggle");
    test_hold();
    test_abort_load();
    test_abort_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_16_sequencer.md
MAC_16_SEQUENCER -- requirements
Module: mac_16_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, sample and result width in bits.
REQ-003 Parameter N_TAPS, default 16, samples per MAC operation; fixed at 16.
REQ-004 Parameter PIPE_LAT, default 5, MAC latency in clocks: 1 multiply level plus 4 adder levels.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 s_data  in  DATA_W  serial input sample.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  sequencer accepts s_data.
REQ-010 a_0 .. a_15  out  DATA_W each  parallel operands to the MAC.
REQ-011 mac_start  out  1  one-cycle pulse when a_0..a_15 are complete.
REQ-012 mac_result  in  DATA_W  MAC sum output.
REQ-013 m_result  out  DATA_W  captured MAC sum.
REQ-014 m_valid  out  1  m_result valid.
REQ-015 m_ready  in  1  downstream accepts m_result.
REQ-016 busy  out  1  high in FIRE, WAIT and OUT.

Function
REQ-017 States SHALL be LOAD, FIRE, WAIT and OUT; reset state is LOAD.
REQ-018 LOAD: s_ready=1; each s_valid&&s_ready edge writes s_data into a_<cnt> and increments the 4-bit cnt.
REQ-019 Sample order SHALL be fixed: the first accepted sample goes to a_0 and the 16th to a_15.
REQ-020 When the sample with cnt=15 is accepted, cnt SHALL wrap to 0 and the state SHALL go to FIRE.
REQ-021 FIRE lasts one cycle with mac_start=1 and s_ready=0, then the state goes to WAIT with the latency counter cleared.
REQ-022 a_0..a_15 SHALL hold constant from FIRE until OUT is left.
REQ-023 WAIT counts PIPE_LAT cycles, then captures mac_result into m_result and goes to OUT.
REQ-024 Timing: if edge E accepts the 16th sample, m_result is captured at edge E+PIPE_LAT+1, and m_valid is high from that edge.
REQ-025 OUT: m_valid=1 and m_result is stable until m_valid&&m_ready; on that edge m_valid goes to 0 and the state goes to LOAD.
REQ-026 s_ready SHALL be 0 in FIRE, WAIT and OUT; s_valid in those states is ignored and the sample is not consumed.
REQ-027 m_ready and s_valid high together in OUT: only the result handshake completes; the first sample is accepted no earlier than the next cycle.
REQ-028 m_ready while m_valid=0 SHALL have no effect.
REQ-029 mac_result SHALL be passed through unmodified; width, truncation and Q16.16 scaling are owned by the MAC.
REQ-030 mac_start SHALL never assert outside FIRE, and at most once per 16 accepted samples.
REQ-031 s_valid deasserting mid-frame SHALL pause loading with no timeout; cnt and the partial a_* are retained.

Reset
REQ-032 Asserting reset SHALL immediately force: state=LOAD, cnt=0, latency counter=0, a_0..a_15=0, m_result=0, m_valid=0, mac_start=0, busy=0.
REQ-033 After reset deasserts, s_ready=1.
REQ-034 Reset during LOAD, WAIT or OUT SHALL discard the partial frame or the pending result with no output handshake.

Structure
REQ-035 Shared package mac_16_pkg SHALL hold DATA_W, N_TAPS, PIPE_LAT and the state enumeration.
REQ-036 Sub-module mac_16_sample_bank: 16 x DATA_W register bank with write enable and 4-bit write index, asynchronously cleared by reset.
REQ-037 FSM, counters and result register SHALL live in mac_16_sequencer.

Verification
REQ-038 The bench SHALL connect the team's 16-tap pipelined MAC (coefficients 65536) to a_*, mac_result, clk and reset.
REQ-039 Samples 1..16 back-to-back, m_ready=1 -> one mac_start pulse; m_result=0x00880000; m_valid rises PIPE_LAT+1 edges after the 16th accept.
REQ-040 Samples 0xFFFF0000 x16 -> m_result=0x00000000 (MAC wraps), m_valid asserted once.
REQ-041 s_valid toggled 1/0 every cycle over 16 samples -> a_i in arrival order; result identical to the back-to-back case.
REQ-042 m_ready held 0 for 20 cycles after m_valid -> m_result stable, s_ready=0, busy=1; m_ready=1 -> LOAD next cycle.
REQ-043 Reset asserted after 9 samples, then 16 new samples 2,2,...,2 -> m_result=0x00200000; no result from the aborted frame.
REQ-044 Reset asserted in WAIT -> m_valid stays 0; the next full frame produces exactly one correct result.
